// File: rtl/r2sdf_seq_ctrl_if.sv
// rtl/r2sdf_seq_ctrl_if.sv - source handshake and stage-control bundle of the R2SDF sequencer
// The master side is the sample source / stage chain; the slave side is the sequencer.
interface r2sdf_seq_ctrl_if #(
  parameter int N = 3
);
  logic                 in_valid;
  logic                 in_sof;
  logic                 in_ready;
  logic                 flush;
  logic                 en;
  logic                 zero_pad;
  logic [N-1:0]         stage_sel;
  logic [N*(N-1)-1:0]   tw_addr;
  logic                 out_valid;
  logic                 out_sof;
  logic                 busy;
  logic                 sof_err;

  modport master (
    output in_valid, in_sof, flush,
    input  in_ready, en, zero_pad, stage_sel, tw_addr,
    input  out_valid, out_sof, busy, sof_err
  );

  modport slave (
    input  in_valid, in_sof, flush,
    output in_ready, en, zero_pad, stage_sel, tw_addr,
    output out_valid, out_sof, busy, sof_err
  );
endinterface

// File: rtl/r2sdf_seq_ctrl.sv
// rtl/r2sdf_seq_ctrl.sv - frame sequencer for an N-stage radix-2 SDF FFT pipeline
// Derives every stage's phase select and twiddle address from one sample index k.
module r2sdf_seq_ctrl #(
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  r2sdf_seq_ctrl_if.slave  bus
);
  localparam int TW  = N - 1;
  localparam int TWW = N * (N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [N-1:0] K_LAST = '1;
  localparam logic [N-1:0] K_PEN  = K_LAST - N'(1);

  logic [1:0]     state_q, state_d;
  logic [N-1:0]   k_q, k_d;
  logic           primed_q, primed_d;
  logic           crossed_q, crossed_d;
  logic           en_q, en_d;
  logic           zero_pad_q, zero_pad_d;
  logic [N-1:0]   stage_sel_q, stage_sel_d;
  logic [TWW-1:0] tw_addr_q, tw_addr_d;
  logic           out_valid_q, out_valid_d;
  logic           out_sof_q, out_sof_d;
  logic           busy_q, busy_d;
  logic           sof_err_q, sof_err_d;

  logic           in_ready;
  logic           accept;
  logic           issue;
  logic           pad;
  logic [N-1:0]   idx;
  logic           primed_eff;

  // Stage n twiddles only in its butterfly half; the low index bits are scaled by 2^(n-1).
  function automatic logic [TW-1:0] tw_field(input logic [N-1:0] k, input int n);
    logic [N-1:0] low;
    low = k & ((N'(1) << (N - n)) - N'(1));
    low = low << (n - 1);
    return k[N-n] ? low[TW-1:0] : '0;
  endfunction

  assign in_ready = (state_q != S_DRAIN);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    primed_d    = primed_q;
    crossed_d   = crossed_q;
    issue       = 1'b0;
    pad         = 1'b0;
    idx         = k_q;
    primed_eff  = primed_q;
    sof_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && bus.in_sof) begin
          issue      = 1'b1;
          idx        = '0;
          primed_eff = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        // A valid sample wins over flush; flush is looked at again next cycle.
        if (accept) begin
          issue = 1'b1;
          if (bus.in_sof) begin
            idx = '0;
            if (k_q != '0) begin
              sof_err_d  = 1'b1;
              primed_eff = 1'b0;
            end
          end
        end else if (bus.flush) begin
          state_d   = S_DRAIN;
          crossed_d = (k_q == '0);
        end
      end
      S_DRAIN: begin
        issue = 1'b1;
        pad   = 1'b1;
        if (k_q == K_LAST) begin
          crossed_d = 1'b1;
        end
        if (k_q == K_PEN && crossed_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      k_d      = idx + N'(1);
      primed_d = primed_eff | (idx == K_LAST);
    end
    if (state_d == S_IDLE) begin
      k_d       = '0;
      primed_d  = 1'b0;
      crossed_d = 1'b0;
    end

    en_d        = issue;
    zero_pad_d  = pad;
    out_valid_d = issue & (primed_eff | (idx == K_LAST));
    out_sof_d   = issue & (idx == K_LAST);
    busy_d      = (state_d != S_IDLE);

    // Stage controls hold their last value through input gaps.
    stage_sel_d = stage_sel_q;
    tw_addr_d   = tw_addr_q;
    if (issue) begin
      for (int n = 1; n <= N; n++) begin
        stage_sel_d[n-1]            = idx[N-n];
        tw_addr_d[(n-1)*TW +: TW]   = tw_field(idx, n);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      primed_q    <= 1'b0;
      crossed_q   <= 1'b0;
      en_q        <= 1'b0;
      zero_pad_q  <= 1'b0;
      stage_sel_q <= '0;
      tw_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      busy_q      <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      primed_q    <= primed_d;
      crossed_q   <= crossed_d;
      en_q        <= en_d;
      zero_pad_q  <= zero_pad_d;
      stage_sel_q <= stage_sel_d;
      tw_addr_q   <= tw_addr_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      busy_q      <= busy_d;
      sof_err_q   <= sof_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.en        = en_q;
  assign bus.zero_pad  = zero_pad_q;
  assign bus.stage_sel = stage_sel_q;
  assign bus.tw_addr   = tw_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.busy      = busy_q;
  assign bus.sof_err   = sof_err_q;
endmodule

// File: tb/tb_r2sdf_seq_ctrl.sv
// tb/tb_r2sdf_seq_ctrl.sv - directed table-driven bench for r2sdf_seq_ctrl with N=3
module tb_r2sdf_seq_ctrl;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  r2sdf_seq_ctrl_if #(.N(3)) bus ();

  r2sdf_seq_ctrl #(.N(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       iv, sof, fl;
    logic       en, zp;
    logic [2:0] sel;
    logic [5:0] tw;
    logic       ov, osof, busy, err, rdy;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] sel_k [0:7];
  logic [5:0] tw_k  [0:7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic iv, sof, fl, en, zp, input logic [2:0] sel,
                              input logic [5:0] tw, input logic ov, osof, busy, err, rdy);
    vec_t v;
    v.iv = iv; v.sof = sof; v.fl = fl; v.en = en; v.zp = zp; v.sel = sel; v.tw = tw;
    v.ov = ov; v.osof = osof; v.busy = busy; v.err = err; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, ".en"},        32'(bus.en),        32'(v.en));
    chk({tag, ".zero_pad"},  32'(bus.zero_pad),  32'(v.zp));
    chk({tag, ".stage_sel"}, 32'(bus.stage_sel), 32'(v.sel));
    chk({tag, ".tw_addr"},   32'(bus.tw_addr),   32'(v.tw));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v.ov));
    chk({tag, ".out_sof"},   32'(bus.out_sof),   32'(v.osof));
    chk({tag, ".busy"},      32'(bus.busy),      32'(v.busy));
    chk({tag, ".sof_err"},   32'(bus.sof_err),   32'(v.err));
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(v.rdy));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic step(input logic iv, input logic sof, input logic fl);
    bus.in_valid = iv;
    bus.in_sof   = sof;
    bus.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pads;
    logic [2:0] last_sel;
    tests = 0;
    fails = 0;

    // stage_sel is k bit-reversed; tw_addr = {stage3=0, stage2, stage1}
    sel_k = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    tw_k  = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h01, 6'h02, 6'h0B};

    vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 3'b000, 6'h00, 0, 0, 0, 0, 1));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1, k == 0, 0, 1, 0, sel_k[k], tw_k[k], k == 7, k == 7, 1, 0, 1));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1, 0, 0, 1, 0, sel_k[k], tw_k[k], 1, k == 7, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, sel_k[7], tw_k[7], 0, 0, 1, 0, 0));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(0, 0, 0, 1, 1, sel_k[k], tw_k[k], 1, 0, k != 6, 0, k == 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, sel_k[6], tw_k[6], 0, 0, 0, 0, 1));

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_vec("reset", mk(0, 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 0, 0, 1));
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].sof, vecs[i].fl);
      chk_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Frame with random source gaps: same per-k controls, en low in gaps
    for (int k = 0; k < 8; k++) begin
      if (k != 0) begin
        int g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          step(0, 0, 0);
          chk($sformatf("gap_k%0d.en", k), 32'(bus.en), 0);
          chk($sformatf("gap_k%0d.out_valid", k), 32'(bus.out_valid), 0);
          chk($sformatf("gap_k%0d.stage_sel", k), 32'(bus.stage_sel), 32'(sel_k[k-1]));
        end
      end
      step(1, k == 0, 0);
      chk($sformatf("gapped_k%0d.en", k), 32'(bus.en), 1);
      chk($sformatf("gapped_k%0d.stage_sel", k), 32'(bus.stage_sel), 32'(sel_k[k]));
      chk($sformatf("gapped_k%0d.tw_addr", k), 32'(bus.tw_addr), 32'(tw_k[k]));
      chk($sformatf("gapped_k%0d.out_valid", k), 32'(bus.out_valid), 32'(k == 7));
    end

    // Mid-frame sof at k=5 resynchronises and drops priming
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0);
      chk($sformatf("pre_err_k%0d.out_valid", k), 32'(bus.out_valid), 1);
    end
    step(1, 1, 0);
    chk("resync.sof_err", 32'(bus.sof_err), 1);
    chk("resync.en", 32'(bus.en), 1);
    chk("resync.stage_sel", 32'(bus.stage_sel), 0);
    chk("resync.out_valid", 32'(bus.out_valid), 0);
    for (int k = 1; k < 8; k++) begin
      step(1, 0, 0);
      chk($sformatf("post_err_k%0d.sof_err", k), 32'(bus.sof_err), 0);
      chk($sformatf("post_err_k%0d.stage_sel", k), 32'(bus.stage_sel), 32'(sel_k[k]));
      chk($sformatf("post_err_k%0d.out_valid", k), 32'(bus.out_valid), 32'(k == 7));
      chk($sformatf("post_err_k%0d.out_sof", k), 32'(bus.out_sof), 32'(k == 7));
    end

    // Flush at k=3: 5 + 7 = 12 pads
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    step(0, 0, 1);
    chk("flush3.en", 32'(bus.en), 0);
    chk("flush3.in_ready", 32'(bus.in_ready), 0);
    pads     = 0;
    last_sel = '0;
    for (int c = 0; c < 40; c++) begin
      step(0, 0, 0);
      if (!bus.en) break;
      pads++;
      last_sel = bus.stage_sel;
      chk($sformatf("flush3_pad%0d.zero_pad", pads), 32'(bus.zero_pad), 1);
      chk($sformatf("flush3_pad%0d.out_valid", pads), 32'(bus.out_valid), 1);
    end
    chk("flush3.pads", 32'(pads), 12);
    chk("flush3.last_sel", 32'(last_sel), 32'(sel_k[6]));
    chk("flush3.busy_after", 32'(bus.busy), 0);

    // Deferred flush, then asynchronous reset in the middle of the drain
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    chk("defer.en", 32'(bus.en), 1);
    chk("defer.stage_sel", 32'(bus.stage_sel), 32'(sel_k[3]));
    chk("defer.in_ready", 32'(bus.in_ready), 1);
    step(0, 0, 1);
    chk("defer.drain_en", 32'(bus.en), 0);
    chk("defer.drain_ready", 32'(bus.in_ready), 0);
    step(0, 0, 0);
    chk("drain_k4.zero_pad", 32'(bus.zero_pad), 1);
    chk("drain_k4.stage_sel", 32'(bus.stage_sel), 32'(sel_k[4]));
    step(0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_vec("async_reset", mk(0, 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 0, 0, 1));
    #1;
    rst_n = 1'b1;
    step(1, 1, 0);
    chk_vec("restart_k0", mk(1, 1, 0, 1, 0, sel_k[0], tw_k[0], 0, 0, 1, 0, 1));
    step(1, 0, 0);
    chk_vec("restart_k1", mk(1, 0, 0, 1, 0, sel_k[1], tw_k[1], 0, 0, 1, 0, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/r2sdf_seq_ctrl.md
# r2sdf_seq_ctrl

Frame sequencer for the N-stage radix-2 single-delay-feedback (R2SDF) FFT pipeline. It tracks the input sample index and produces, from that one index, every control each butterfly stage needs:
- phase select (shift vs. butterfly);
- twiddle ROM address;
- common advance enable.

It also frames the output stream (valid, start-of-frame) and zero-pads a drain at end of stream. It sits between the sample source and the chain of butterfly stages. All stages stall together on its enable.

## Interface
- N, 3: log2 of FFT size; number of butterfly stages.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source sample present.
- in_sof  in  1  first sample of a frame; qualified by in_valid.
- in_ready  out  1  controller accepts a source sample this cycle.
- flush  in  1  end-of-stream request; drain pipeline with zero pads.
- en  out  1  all stages advance one sample this cycle.
- zero_pad  out  1  datapath must substitute 0+0j for the input sample.
- stage_sel  out  N  bit n-1 = 1: stage n in butterfly phase; 0: shift phase.
- tw_addr  out  N*(N-1)  twiddle ROM index for stage n in field [(n-1)*(N-1) +: N-1].
- out_valid  out  1  last-stage output sample is a real frame sample.
- out_sof  out  1  out_valid sample is output index 0 of a frame.
- busy  out  1  state is not IDLE.
- sof_err  out  1  one-cycle pulse: in_sof arrived mid-frame.

## Operation
- State: FSM {IDLE, RUN, DRAIN}; sample index k (N bits); primed flag; crossed flag.
- Accept: a source sample is accepted when in_valid & in_ready. in_ready = 1 in IDLE and RUN, 0 in DRAIN.
- IDLE:
  - accepted sample with in_sof: k←1 (this sample is k=0); → RUN.
  - accepted sample without in_sof: dropped; no en.
  - flush: ignored.
- RUN, accepted sample:
  - Issues en for index k; then k←k+1 mod 2^N.
  - in_sof with k≠0: sof_err pulse, pipeline resync. The sample is treated as k=0, primed←0.
  - in_sof with k=0: normal.
  - in_sof absent with k=0: the frame continues at index 0 (back-to-back frames without an explicit sof are legal).
- RUN, flush with in_valid=0: → DRAIN; crossed←(k==0).
  - flush with in_valid=1 is deferred: the sample is accepted, flush is re-sampled next cycle.
- DRAIN:
  - en=1 with zero_pad=1 every cycle; k advances as in RUN.
  - crossed←1 on the 2^N−1→0 wrap.
  - The pad at k=2^N−2 with crossed=1 already set is the last pad; then → IDLE, primed←0.
  - Drain length: 2^N−1 pads if entered at k=0; otherwise (2^N−j)+(2^N−1) pads for entry k=j. A partial frame is thus zero-padded and output in full.
- Per-stage controls for the enabled index k:
  - stage_sel[n-1] = k[N-n].
  - tw_addr_n = stage_sel[n-1] ? (k[N-n-1:0] << (n-1)) : 0, width N-1.
  - Stage N field is always 0. Table has 2^(N-1) entries.
- Output framing (pipeline latency 2^N−1 enabled samples):
  - Output index = (k+1) mod 2^N.
  - primed←1 on the enabled index k=2^N−1.
  - out_valid = en & primed (including the priming sample).
  - out_sof = out_valid & (k==2^N−1).
- Reset mid-operation: FSM→IDLE, k=0, primed=0, crossed=0. In-flight frames are discarded.

## Timing
- All outputs are registered. The controls for a sample accepted at edge t (or a pad issued at edge t) appear during cycle t+1, aligned with the datapath's registered input sample.
- in_ready is combinational from state only: no in_valid→in_ready path.
- Reset values: en, zero_pad, stage_sel, tw_addr, out_valid, out_sof, busy, sof_err = 0; in_ready = 1.
- busy rises in the cycle after the IDLE→RUN accept. It falls in the cycle after the last drain pad is issued.
- sof_err lasts exactly one cycle and does not stall; en still issues for the resync sample.
- Gaps in in_valid during RUN freeze k, primed and all outputs; en=0, out_valid=0.

## Test plan
- N=3, in_sof+8 contiguous valids from IDLE:
  - en high for 8 cycles.
  - stage_sel bit0/1/2 = k[2]/k[1]/k[0].
  - stage-1 tw_addr = 0,0,0,0,0,1,2,3.
  - stage-2 tw_addr = 0,0,0,2,0,0,0,2.
  - out_sof and first out_valid on k=7.
- Two back-to-back frames, sof only on the first: out_valid continuous from first k=7; out_sof every 8 samples; sof_err never.
- Random in_valid gaps during a frame: k, stage_sel and tw_addr sequence are identical to the gapless case, compressed to enabled cycles; en low in gaps.
- in_sof at k=5: sof_err pulse; k restarts at 0; out_valid low until the new frame's k=7.
- flush at k=0 after two frames: 7 pads (zero_pad=1, in_ready=0), last at k=6; out_valid through the pad at k=6; then IDLE, busy=0. Flush at k=3: 5+7=12 pads.
- rst_n asserted mid-DRAIN (asynchronous, between edges): all outputs immediately at reset values; in_ready=1; a following in_sof restarts at k=0.
